// File: rtl/alu_regfile_mem_seq.sv
// Register file + ALU + synchronous data memory behind a command/response handshake.
// IDLE -> EXEC -> (MWAIT for LOAD) -> RESP; the response is held until rsp_ready_i is high.
module alu_regfile_mem_seq #(
    parameter int DATA_W    = 16,
    parameter int NUM_REGS  = 16,
    parameter int MEM_DEPTH = 1024,
    parameter int RSEL_W    = $clog2(NUM_REGS),
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_op_i,
    input  logic [RSEL_W-1:0] cmd_rd_i,
    input  logic [RSEL_W-1:0] cmd_ra_i,
    input  logic [RSEL_W-1:0] cmd_rb_i,
    input  logic [DATA_W-1:0] cmd_imm_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    output logic [4:0]        flags_o,
    input  logic [RSEL_W-1:0] dbg_sel_i,
    output logic [DATA_W-1:0] dbg_data_o
);
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADDC  = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_LSH   = 4'd7;
    localparam logic [3:0] OP_RSH   = 4'd8;
    localparam logic [3:0] OP_CMP   = 4'd9;
    localparam logic [3:0] OP_MOVI  = 4'd10;
    localparam logic [3:0] OP_LOAD  = 4'd11;
    localparam logic [3:0] OP_STORE = 4'd12;
    localparam logic [DATA_W-1:0] SH_LIM = DATA_W'(DATA_W);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MWAIT, S_RESP} state_t;
    state_t state_q, state_d;

    logic [3:0]        op_q;
    logic [RSEL_W-1:0] rd_q, ra_q, rb_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] mem_rdata_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic [4:0]        flags_q;

    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic [DATA_W:0]   add_full, sub_full;
    logic [AW-1:0]     mem_addr;
    logic              cin, reg_we, illegal, arith, c_bit, f_bit;
    logic [4:0]        flags_d;

    assign op_a     = regs_q[ra_q];
    assign op_b     = regs_q[rb_q];
    assign cin      = (op_q == OP_ADDC) && flags_q[4];
    assign add_full = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, cin};
    assign sub_full = {1'b0, op_a} - {1'b0, op_b};
    // Only the low AW bits of base+offset matter, which gives the modulo wrap for free.
    assign mem_addr = op_a[AW-1:0] + imm_q[AW-1:0];

    always_comb begin
        alu_res = '0;
        reg_we  = 1'b0;
        illegal = 1'b0;
        arith   = 1'b0;
        c_bit   = 1'b0;
        f_bit   = 1'b0;
        case (op_q)
            OP_ADD, OP_ADDC: begin
                alu_res = add_full[MSB:0];
                reg_we  = 1'b1;
                arith   = 1'b1;
                c_bit   = add_full[DATA_W];
                f_bit   = (op_a[MSB] == op_b[MSB]) && (add_full[MSB] != op_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_full[MSB:0];
                reg_we  = (op_q == OP_SUB);
                arith   = 1'b1;
                c_bit   = sub_full[DATA_W];
                f_bit   = (op_a[MSB] != op_b[MSB]) && (sub_full[MSB] != op_a[MSB]);
            end
            OP_AND: begin alu_res = op_a & op_b; reg_we = 1'b1; end
            OP_OR:  begin alu_res = op_a | op_b; reg_we = 1'b1; end
            OP_XOR: begin alu_res = op_a ^ op_b; reg_we = 1'b1; end
            OP_NOT: begin alu_res = ~op_a;       reg_we = 1'b1; end
            OP_LSH: begin
                alu_res = (op_b >= SH_LIM) ? '0 : (op_a << op_b);
                reg_we  = 1'b1;
            end
            OP_RSH: begin
                alu_res = (op_b >= SH_LIM) ? '0 : (op_a >> op_b);
                reg_we  = 1'b1;
            end
            OP_MOVI:  begin alu_res = imm_q; reg_we = 1'b1; end
            OP_LOAD:  alu_res = '0;
            OP_STORE: alu_res = op_b;
            default:  illegal = 1'b1;
        endcase
        flags_d = flags_q;
        if (arith) begin
            flags_d = {c_bit, op_a < op_b, f_bit, alu_res == '0, $signed(op_a) < $signed(op_b)};
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) state_d = S_EXEC;
            end
            S_EXEC:  state_d = (op_q == OP_LOAD) ? S_MWAIT : S_RESP;
            S_MWAIT: state_d = S_RESP;
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            op_q       <= '0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            imm_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            flags_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q  <= cmd_op_i;
                        rd_q  <= cmd_rd_i;
                        ra_q  <= cmd_ra_i;
                        rb_q  <= cmd_rb_i;
                        imm_q <= cmd_imm_i;
                    end
                end
                S_EXEC: begin
                    if (reg_we) regs_q[rd_q] <= alu_res;
                    flags_q    <= flags_d;
                    rsp_data_q <= alu_res;
                    rsp_err_q  <= illegal;
                end
                S_MWAIT: begin
                    regs_q[rd_q] <= mem_rdata_q;
                    rsp_data_q   <= mem_rdata_q;
                end
                default: ;
            endcase
        end
    end

    // No reset here so the array maps onto RAM; an async reset drops state_q out of EXEC,
    // so an interrupted STORE never reaches its write edge.
    always_ff @(posedge clk_i) begin
        if (state_q == S_EXEC) begin
            if (op_q == OP_STORE) mem_q[mem_addr] <= op_b;
            mem_rdata_q <= mem_q[mem_addr];
        end
    end

    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;
    assign flags_o    = flags_q;
    assign dbg_data_o = regs_q[dbg_sel_i];

endmodule

// File: tb/tb_alu_regfile_mem_seq.sv
// Directed bench for alu_regfile_mem_seq: architectural model plus hand-computed pins.
module tb_alu_regfile_mem_seq;
    localparam logic [3:0] ADD = 4'd0, ADDC = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                           XOR_ = 4'd5, NOT_ = 4'd6, LSH = 4'd7, RSH = 4'd8, CMP = 4'd9,
                           MOVI = 4'd10, LOAD = 4'd11, STORE = 4'd12;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0, cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
    logic [15:0] cmd_imm = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [4:0]  flags;
    logic [3:0]  dbg_sel = '0;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_reg [16];
    logic [15:0] m_mem [1024];
    logic [4:0]  m_flags;
    logic [15:0] exp_data = '0;
    logic        exp_err = 1'b0;
    logic [15:0] fib [6] = '{16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13};

    alu_regfile_mem_seq dut (
        .clk_i(clk), .reset_i(reset_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_ra_i(cmd_ra), .cmd_rb_i(cmd_rb),
        .cmd_imm_i(cmd_imm),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .flags_o(flags),
        .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Every cycle a response is held it must match the model and block new commands.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            chk("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
            chk("cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
        end
    end

    // Architectural effect of one command on the model state.
    task automatic model_step(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                              input logic [3:0] rb, input logic [15:0] imm,
                              output logic [15:0] d, output logic e, output int lat);
        logic [15:0] a, b;
        int s, ss, cin, addr;
        a = m_reg[ra];
        b = m_reg[rb];
        d = '0;
        e = 1'b0;
        lat = 2;
        addr = (int'(a) + int'(imm)) % 1024;
        case (op)
            ADD, ADDC: begin
                cin = (op == ADDC) ? int'(m_flags[4]) : 0;
                s  = int'(a) + int'(b) + cin;
                ss = int'($signed(a)) + int'($signed(b)) + cin;
                d  = s[15:0];
                m_flags = {s > 65535, a < b, (ss > 32767) || (ss < -32768), d == 16'd0,
                           $signed(a) < $signed(b)};
                m_reg[rd] = d;
            end
            SUB, CMP: begin
                s  = int'(a) - int'(b);
                ss = int'($signed(a)) - int'($signed(b));
                d  = s[15:0];
                m_flags = {s < 0, a < b, (ss > 32767) || (ss < -32768), d == 16'd0,
                           $signed(a) < $signed(b)};
                if (op == SUB) m_reg[rd] = d;
            end
            AND_:  begin d = a & b; m_reg[rd] = d; end
            OR_:   begin d = a | b; m_reg[rd] = d; end
            XOR_:  begin d = a ^ b; m_reg[rd] = d; end
            NOT_:  begin d = ~a;    m_reg[rd] = d; end
            LSH:   begin d = (b >= 16) ? 16'd0 : (a << b); m_reg[rd] = d; end
            RSH:   begin d = (b >= 16) ? 16'd0 : (a >> b); m_reg[rd] = d; end
            MOVI:  begin d = imm; m_reg[rd] = d; end
            LOAD:  begin d = m_mem[addr]; m_reg[rd] = d; lat = 3; end
            STORE: begin m_mem[addr] = b; d = b; end
            default: e = 1'b1;
        endcase
    endtask

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1 chk($sformatf("%s_r%0d", tag, i), {16'd0, dbg_data}, {16'd0, m_reg[i]});
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [15:0] imm, input int hold);
        int lat, exp_lat;
        model_step(op, rd, ra, rb, imm, exp_data, exp_err, exp_lat);
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        rsp_ready = 1'b0;
        @(posedge clk);
        lat = 1;
        #1 cmd_valid = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk($sformatf("latency_op%0d", op), lat, exp_lat);
        repeat (hold) @(posedge clk);
        #1 chk("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
        chk("flags", {27'd0, flags}, {27'd0, m_flags});
        sweep_regs($sformatf("op%0d", op));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        m_flags = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_flags", {27'd0, flags}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        sweep_regs("rst");
    endtask

    task automatic lit(input string name, input logic [3:0] r, input logic [15:0] v);
        dbg_sel = r;
        #1 chk(name, {16'd0, dbg_data}, {16'd0, v});
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fibonacci chain, stored to 1000..1005 and read back
        issue(MOVI, 4'd0, 4'd0, 4'd0, 16'd1, 0);
        issue(MOVI, 4'd15, 4'd0, 4'd0, 16'd0, 0);
        issue(ADD, 4'd1, 4'd0, 4'd15, 16'd0, 0);
        for (int n = 1; n <= 5; n++) issue(ADD, 4'(n + 1), 4'(n - 1), 4'(n), 16'd0, 0);
        for (int i = 0; i < 6; i++) lit($sformatf("fib_r%0d", i + 1), 4'(i + 1), fib[i]);
        for (int i = 0; i < 6; i++) issue(STORE, 4'd0, 4'd15, 4'(i + 1), 16'(1000 + i), 0);
        for (int i = 0; i < 6; i++) begin
            issue(LOAD, 4'd8, 4'd15, 4'd0, 16'(1000 + i), 0);
            lit($sformatf("fib_load%0d", i), 4'd8, fib[i]);
        end

        // Carry chain
        do_reset();
        issue(MOVI, 4'd1, 4'd0, 4'd0, 16'hFFFF, 0);
        issue(MOVI, 4'd2, 4'd0, 4'd0, 16'd1, 0);
        issue(ADD, 4'd3, 4'd1, 4'd2, 16'd0, 0);
        lit("carry_r3", 4'd3, 16'd0);
        chk("carry_C", {31'd0, flags[4]}, 32'd1);
        chk("carry_Z", {31'd0, flags[1]}, 32'd1);
        issue(ADDC, 4'd4, 4'd0, 4'd0, 16'd0, 0);
        lit("addc_r4", 4'd4, 16'd1);
        chk("addc_C", {31'd0, flags[4]}, 32'd0);
        issue(MOVI, 4'd4, 4'd0, 4'd0, 16'h7FFF, 0);
        issue(ADD, 4'd6, 4'd4, 4'd2, 16'd0, 0);
        chk("ovf_F", {31'd0, flags[2]}, 32'd1);

        // CMP / SUB
        do_reset();
        issue(MOVI, 4'd1, 4'd0, 4'd0, 16'd5, 0);
        issue(MOVI, 4'd2, 4'd0, 4'd0, 16'hFFFB, 0);
        issue(CMP, 4'd7, 4'd1, 4'd2, 16'd0, 0);
        chk("cmp_L", {31'd0, flags[3]}, 32'd1);
        chk("cmp_N", {31'd0, flags[0]}, 32'd0);
        chk("cmp_Z", {31'd0, flags[1]}, 32'd0);
        lit("cmp_no_wb", 4'd7, 16'd0);
        issue(SUB, 4'd3, 4'd2, 4'd2, 16'd0, 0);
        lit("sub_r3", 4'd3, 16'd0);
        chk("sub_Z", {31'd0, flags[1]}, 32'd1);

        // Address wrap and backpressure
        do_reset();
        issue(MOVI, 4'd1, 4'd0, 4'd0, 16'd1023, 0);
        issue(MOVI, 4'd5, 4'd0, 4'd0, 16'h1234, 0);
        issue(STORE, 4'd0, 4'd1, 4'd5, 16'd2, 0);
        issue(LOAD, 4'd6, 4'd0, 4'd0, 16'd1, 10);
        lit("wrap_load", 4'd6, 16'h1234);
        issue(ADD, 4'd7, 4'd5, 4'd5, 16'd0, 10);

        // Illegal opcodes, shifts, logic ops, rd==ra
        issue(MOVI, 4'd1, 4'd0, 4'd0, 16'hABCD, 0);
        issue(MOVI, 4'd2, 4'd0, 4'd0, 16'd16, 0);
        issue(4'd14, 4'd1, 4'd1, 4'd2, 16'h5555, 0);
        lit("illegal_r1", 4'd1, 16'hABCD);
        issue(4'd13, 4'd2, 4'd1, 4'd1, 16'd0, 0);
        issue(4'd15, 4'd3, 4'd1, 4'd1, 16'd0, 0);
        issue(LSH, 4'd3, 4'd1, 4'd2, 16'd0, 0);
        lit("lsh16", 4'd3, 16'd0);
        issue(MOVI, 4'd4, 4'd0, 4'd0, 16'h8000, 0);
        issue(MOVI, 4'd5, 4'd0, 4'd0, 16'd15, 0);
        issue(RSH, 4'd6, 4'd4, 4'd5, 16'd0, 0);
        lit("rsh15", 4'd6, 16'd1);
        issue(LSH, 4'd7, 4'd1, 4'd5, 16'd0, 0);
        lit("lsh15", 4'd7, 16'h8000);
        issue(AND_, 4'd8, 4'd1, 4'd4, 16'd0, 0);
        issue(OR_, 4'd9, 4'd1, 4'd5, 16'd0, 0);
        lit("or", 4'd9, 16'hABCF);
        issue(XOR_, 4'd10, 4'd1, 4'd1, 16'd0, 0);
        issue(NOT_, 4'd11, 4'd1, 4'd0, 16'd0, 0);
        lit("not", 4'd11, 16'h5432);
        issue(ADD, 4'd1, 4'd1, 4'd1, 16'd0, 0);
        lit("rd_eq_ra", 4'd1, 16'h579A);

        // Reset in the middle of a STORE
        do_reset();
        issue(MOVI, 4'd2, 4'd0, 4'd0, 16'd7, 0);
        issue(STORE, 4'd0, 4'd0, 4'd2, 16'd500, 0);
        issue(MOVI, 4'd2, 4'd0, 4'd0, 16'd9, 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = STORE; cmd_rd = 4'd0; cmd_ra = 4'd0; cmd_rb = 4'd2;
        cmd_imm = 16'd500;
        @(posedge clk);
        #2 reset_n = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1 chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        sweep_regs("midrst");
        issue(LOAD, 4'd3, 4'd0, 4'd0, 16'd500, 0);
        lit("midrst_mem500", 4'd3, 16'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
